hazard_ctrl_unit: RTL

- Producer of the stall/flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards, taken branches resolved in EX, and jumps decoded in ID.
- Runs a small FSM that freezes the pipeline while the data memory is not ready, with a timeout.
- Sits beside the pipeline registers in the CPU core and drives their write-enable and flush inputs.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_unit_if.sv | 38 +++
 rtl/hazard_ctrl_unit_load_use_detect.sv | 17 +
 rtl/hazard_ctrl_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encodings, register-zero constant, widths.
package pipeline_ctrl_pkg;

   localparam int unsigned REG_W     = 5;
   localparam int unsigned CNT_W_DEF = 5;
   localparam int unsigned PERF_W    = 32;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1
   } state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side hazard inputs and stall/flush controls of hazard_ctrl_unit.
interface hazard_ctrl_unit_if;
   import pipeline_ctrl_pkg::*;

   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              id_uses_rt;
   logic              id_jump;
   logic              ex_mem_read;
   logic [REG_W-1:0]  ex_rt;
   logic              ex_branch_taken;
   logic              mem_req;
   logic              mem_ready;
   logic              o_pc_write;
   logic              o_if_id_write;
   logic              o_if_id_flush;
   logic              o_id_ex_flush;
   logic              o_pipe_stall;
   logic              o_mem_err;
   logic [1:0]        o_state;
   logic [PERF_W-1:0] o_stall_cycles;
   logic [PERF_W-1:0] o_flush_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
             ex_branch_taken, mem_req, mem_ready,
      input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
             o_pipe_stall, o_mem_err, o_state, o_stall_cycles, o_flush_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
             ex_branch_taken, mem_req, mem_ready,
      output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
             o_pipe_stall, o_mem_err, o_state, o_stall_cycles, o_flush_count
   );

endinterface

// File: rtl/hazard_ctrl_unit_load_use_detect.sv
// Combinational load-use compare between the load in EX and the source registers in ID.
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rt_i,
   output logic             load_use_c_o
);

   // $0 is hard-wired, so a load targeting it never creates a dependency
   assign load_use_c_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                         ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush control for PC, IF/ID and ID/EX, with a data-memory wait FSM and timeout.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_unit_if.slave hz
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             timeout;
   logic             mem_busy;
   logic             load_use;

   load_use_detect u_load_use (
      .ex_mem_read_i (hz.ex_mem_read),
      .ex_rt_i       (hz.ex_rt),
      .id_rs_i       (hz.id_rs),
      .id_rt_i       (hz.id_rt),
      .id_uses_rt_i  (hz.id_uses_rt),
      .load_use_c_o  (load_use)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign timeout  = (state_q == S_WAIT) && !hz.mem_ready &&
                     (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
   assign mem_busy = ((state_q == S_RUN) && hz.mem_req && !hz.mem_ready) ||
                     ((state_q == S_WAIT) && !hz.mem_ready && !timeout);

   // Wait FSM: a timeout releases the pipeline exactly like mem_ready, but latches the error
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_RUN: begin
            if (hz.mem_req && !hz.mem_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (hz.mem_ready) begin
               state_d = S_RUN;
            end else if (timeout) begin
               state_d = S_RUN;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // Zero-latency control outputs in priority order; a memory stall holds everything in place
   always_comb begin
      hz.o_pc_write    = 1'b1;
      hz.o_if_id_write = 1'b1;
      hz.o_if_id_flush = 1'b0;
      hz.o_id_ex_flush = 1'b0;
      hz.o_pipe_stall  = 1'b0;
      if (reset) begin
         hz.o_pc_write    = 1'b0;
         hz.o_if_id_write = 1'b0;
      end else if (mem_busy) begin
         hz.o_pipe_stall  = 1'b1;
         hz.o_pc_write    = 1'b0;
         hz.o_if_id_write = 1'b0;
      end else if (hz.ex_branch_taken) begin
         hz.o_if_id_flush = 1'b1;
         hz.o_id_ex_flush = 1'b1;
      end else if (load_use) begin
         hz.o_pc_write    = 1'b0;
         hz.o_if_id_write = 1'b0;
         hz.o_id_ex_flush = 1'b1;
      end else if (hz.id_jump) begin
         hz.o_if_id_flush = 1'b1;
      end
   end

   assign hz.o_mem_err = err_q;
   assign hz.o_state   = 2'(state_q);

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!hz.o_pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
      if ((hz.o_if_id_flush || hz.o_id_ex_flush) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.o_stall_cycles = stall_cnt_q;
   assign hz.o_flush_count  = flush_cnt_q;
`else
   assign hz.o_stall_cycles = '0;
   assign hz.o_flush_count  = '0;
`endif

endmodule
